icache: RTL and testbench
=========================

Name: icache

Overview:
- Direct-mapped, read-only instruction cache; the responder end of the fetch-unit I$ interface (icache_REN/icache_addr/icache_halt in, icache_hit/icache_load out).
- Sits between the fetch unit and the memory controller's instruction port.
- Serves hits combinationally in the same cycle.
- On a miss, runs a two-word block-fill FSM against memory, then hits on the next cycle.
- On a halt request, stops serving permanently until reset.

Parameters:
- ICACHE_FRAMES, 8, number of frames; power of two, minimum 2.
- ICACHE_BLOCK_WORDS, 2, words per block; fixed at 2, and the FSM assumes 2.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset; asynchronous, active-high.
- icache_REN  in  1  fetch read enable.
- icache_addr  in  32  fetch byte address, word aligned; bits [1:0] are ignored.
- icache_halt  in  1  halt request from fetch.
- icache_hit  out  1  icache_load is valid this cycle.
- icache_load  out  32  instruction word.
- mem_iREN  out  1  memory instruction read request.
- mem_iaddr  out  32  memory word address.
- mem_iwait  in  1  memory busy; 0 means mem_iload is valid this cycle.
- mem_iload  in  32  memory read data.
- hit_count  out  32  perf counter (see Optional Feature).
- miss_count  out  32  perf counter (see Optional Feature).

Behaviour:
- Address split (defaults):
  - [1:0] byte offset, ignored.
  - [2] word-in-block.
  - [2+LOG_ICACHE_FRAMES:3] index.
  - Remaining upper bits are the tag (26 bits at default).
- Frame state: valid bit, tag, 2 data words. On reset: all valid=0, tags=0, data=0.
- FSM states: IDLE, FILL0, FILL1, HALTED. Reset state is IDLE.
- IDLE:
  - icache_hit = icache_REN & valid[idx] & (tag[idx]==addr tag) & ~icache_halt.
  - icache_load = data[idx][word] always (0 after reset).
  - mem_iREN=0, mem_iaddr=0.
  - Transitions: icache_halt -> HALTED (halt has priority); else REN & miss -> FILL0; else stay.
  - The miss address is captured into a fill register {tag, idx}, so a later change of icache_addr does not redirect an in-flight fill.
- FILL0:
  - mem_iREN=1, mem_iaddr={fill tag, idx, 1'b0, 2'b00}, icache_hit=0.
  - On ~mem_iwait: write data[idx][0]=mem_iload, clear valid[idx], go FILL1.
- FILL1:
  - mem_iREN=1, mem_iaddr={fill tag, idx, 1'b1, 2'b00}, icache_hit=0.
  - On ~mem_iwait: write data[idx][1], set tag[idx]=fill tag and valid[idx]=1, go IDLE.
- Miss latency: 1 cycle to enter FILL0, plus wait cycles, plus 2 data cycles. The first hit is in the cycle after FILL1 completes, provided the fetch address still matches; otherwise IDLE re-evaluates the new address.
- Zero-wait memory: the fill completes in exactly 2 cycles.
- Halt during FILL0 or FILL1:
  - The fill aborts immediately and the FSM goes to HALTED.
  - A frame left partly filled stays invalid; no stale-tag alias is possible.
- HALTED: icache_hit=0, mem_iREN=0, mem_iaddr=0. The FSM is absorbing; only RST exits.
- REN low during a fill: the fill still completes.
- Reset asserted mid-fill: immediate return to IDLE with all frames invalid and mem_iREN=0.
- Data reuse: both words of a filled block are valid afterwards, so PC and PC+4 within a block hit without a second fill.

Optional Feature:
- Macro: ICACHE_PERF_COUNTERS_EN.
- When defined:
  - hit_count increments on every cycle with icache_hit=1.
  - miss_count increments on every IDLE->FILL0 transition.
  - Both counters are 32-bit, wrap modulo 2^32, reset to 0, and freeze in HALTED.
- When undefined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- Add to core_types_pkg:
  - ICACHE_FRAMES and LOG_ICACHE_FRAMES.
  - icache_tag_t.
  - icache_frame_t: packed struct of valid, tag, data[2].
  - icache_state_t enum: IDLE, FILL0, FILL1, HALTED.
- No sub-module: a single flat module; the frame array and the FSM are tightly coupled.

Test Plan:
- Cold miss: after reset, REN=1, addr=0x0000_0040, memory returns 0xAAAA0001 / 0xAAAA0002 with 0 wait.
  - Required: mem_iaddr 0x40 then 0x44.
  - Then hit=1 with load=0xAAAA0001; addr 0x44 then hits with load=0xAAAA0002 and no new mem_iREN.
- Conflict eviction: fill addr 0x40, then access addr 0x240 (same index, different tag).
  - Required: a fill at 0x240/0x244; re-access of 0x40 misses and refills.
- Wait states: mem_iwait=1 for 3 cycles on each word.
  - Required: mem_iaddr held stable during each wait; hit is asserted exactly 1 cycle after the second ~iwait.
- Address change mid-fill: the miss on 0x40 starts, then icache_addr switches to 0x80.
  - Required: the 0x40 fill completes, then a new fill begins for 0x80.
- Halt mid-fill: assert icache_halt in FILL1.
  - Required: next cycle mem_iREN=0 and hit=0 permanently; after RST, access to 0x40 misses.
- ICACHE_PERF_COUNTERS_EN: 1 miss plus 3 subsequent hits.
  - Required: miss_count=1, hit_count=3.
  - Without the macro, both read 0.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types for the direct-mapped instruction cache: frame layout, index/tag widths, FSM states.
package icache_pkg;

   localparam int unsigned ICACHE_FRAMES      = 8;
   localparam int unsigned LOG_ICACHE_FRAMES  = $clog2(ICACHE_FRAMES);
   localparam int unsigned ICACHE_BLOCK_WORDS = 2;
   localparam int unsigned ICACHE_TAG_W       = 32 - 3 - LOG_ICACHE_FRAMES;

   typedef logic [ICACHE_TAG_W-1:0]      icache_tag_t;
   typedef logic [LOG_ICACHE_FRAMES-1:0] icache_idx_t;

   typedef struct packed {
      logic                                 valid;
      icache_tag_t                          tag;
      logic [ICACHE_BLOCK_WORDS-1:0][31:0]  data;
   } icache_frame_t;

   typedef enum logic [1:0] {
      IDLE,
      FILL0,
      FILL1,
      HALTED
   } icache_state_t;

endpackage

// File: rtl/icache.sv
// Direct-mapped read-only I$ with a two-word block-fill FSM and a permanent halt state.
// Optional perf counters are built when ICACHE_PERF_COUNTERS_EN is defined.
module icache
   import icache_pkg::*;
(
   input  logic        CLK,
   input  logic        RST,
   input  logic        icache_REN,
   input  logic [31:0] icache_addr,
   input  logic        icache_halt,
   output logic        icache_hit,
   output logic [31:0] icache_load,
   output logic        mem_iREN,
   output logic [31:0] mem_iaddr,
   input  logic        mem_iwait,
   input  logic [31:0] mem_iload,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
);

   icache_state_t state_q;
   icache_frame_t frames_q [ICACHE_FRAMES];
   icache_tag_t   fill_tag_q;
   icache_idx_t   fill_idx_q;

   icache_tag_t   addr_tag;
   icache_idx_t   addr_idx;
   logic          addr_word;
   logic          unused_addr_bits;
   icache_frame_t lookup;
   logic          tag_match;
   logic          miss;
   logic          filling;

   assign addr_tag         = icache_addr[31 -: ICACHE_TAG_W];
   assign addr_idx         = icache_addr[3 +: LOG_ICACHE_FRAMES];
   assign addr_word        = icache_addr[2];
   assign unused_addr_bits = ^icache_addr[1:0];

   assign lookup      = frames_q[addr_idx];
   assign tag_match   = lookup.valid && (lookup.tag == addr_tag);
   assign miss        = icache_REN && !tag_match;
   assign icache_hit  = (state_q == IDLE) && icache_REN && tag_match && !icache_halt;
   assign icache_load = lookup.data[addr_word];

   // Fill requests come from the captured miss address, never the live fetch address.
   assign filling   = (state_q == FILL0) || (state_q == FILL1);
   assign mem_iREN  = filling;
   assign mem_iaddr = filling ? {fill_tag_q, fill_idx_q, (state_q == FILL1), 2'b00} : '0;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= IDLE;
         fill_tag_q <= '0;
         fill_idx_q <= '0;
         for (int unsigned i = 0; i < ICACHE_FRAMES; i++) begin
            frames_q[i] <= '0;
         end
      end else begin
         case (state_q)
            IDLE: begin
               if (icache_halt) begin
                  state_q <= HALTED;
               end else if (miss) begin
                  state_q    <= FILL0;
                  fill_tag_q <= addr_tag;
                  fill_idx_q <= addr_idx;
               end
            end
            FILL0: begin
               // Invalidate on the first word so an aborted fill can never alias the old tag.
               if (icache_halt) begin
                  state_q <= HALTED;
               end else if (!mem_iwait) begin
                  frames_q[fill_idx_q].data[0] <= mem_iload;
                  frames_q[fill_idx_q].valid   <= 1'b0;
                  state_q                      <= FILL1;
               end
            end
            FILL1: begin
               if (icache_halt) begin
                  state_q <= HALTED;
               end else if (!mem_iwait) begin
                  frames_q[fill_idx_q].data[1] <= mem_iload;
                  frames_q[fill_idx_q].tag     <= fill_tag_q;
                  frames_q[fill_idx_q].valid   <= 1'b1;
                  state_q                      <= IDLE;
               end
            end
            HALTED: state_q <= HALTED;
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef ICACHE_PERF_COUNTERS_EN
   logic [31:0] hit_count_q;
   logic [31:0] miss_count_q;

   // Both counters stop naturally in HALTED: no hits and no IDLE->FILL0 transitions.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         hit_count_q  <= '0;
         miss_count_q <= '0;
      end else begin
         if (icache_hit) begin
            hit_count_q <= hit_count_q + 32'd1;
         end
         if ((state_q == IDLE) && !icache_halt && miss) begin
            miss_count_q <= miss_count_q + 32'd1;
         end
      end
   end

   assign hit_count  = hit_count_q;
   assign miss_count = miss_count_q;
`else
   assign hit_count  = '0;
   assign miss_count = '0;
`endif

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios plus randomized accesses against a tag-array model.
module tb_icache;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        icache_REN = 1'b0;
   logic [31:0] icache_addr = '0;
   logic        icache_halt = 1'b0;
   logic        icache_hit;
   logic [31:0] icache_load;
   logic        mem_iREN;
   logic [31:0] mem_iaddr;
   logic        mem_iwait;
   logic [31:0] mem_iload;
   logic [31:0] hit_count;
   logic [31:0] miss_count;

   int compared   = 0;
   int mismatched = 0;
   int wait_cfg   = 0;

   logic [31:0] accepted [$];
   bit          m_valid [8];
   logic [25:0] m_tag   [8];

   bit          mem_have = 0;
   logic [31:0] mem_last = '0;
   int          mem_cnt  = 0;

   always #5 CLK = ~CLK;

   icache dut (
      .CLK         (CLK),
      .RST         (RST),
      .icache_REN  (icache_REN),
      .icache_addr (icache_addr),
      .icache_halt (icache_halt),
      .icache_hit  (icache_hit),
      .icache_load (icache_load),
      .mem_iREN    (mem_iREN),
      .mem_iaddr   (mem_iaddr),
      .mem_iwait   (mem_iwait),
      .mem_iload   (mem_iload),
      .hit_count   (hit_count),
      .miss_count  (miss_count)
   );

   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      logic [31:0] w;
      w = {a[31:2], 2'b00};
      if (w == 32'h40) return 32'hAAAA_0001;
      if (w == 32'h44) return 32'hAAAA_0002;
      return (w * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   // Memory: wait_cfg busy cycles per word, then one data cycle; logs each accepted word address.
   always @(negedge CLK) begin
      if (!mem_iREN) begin
         mem_have  = 0;
         mem_iwait = 1'b1;
         mem_iload = $urandom;
      end else begin
         if (mem_have) begin
            compared++;
            if (mem_iaddr !== mem_last) begin
               mismatched++;
               $display("FAIL iaddr_stable: got %h required %h", mem_iaddr, mem_last);
            end
         end else begin
            mem_have = 1;
            mem_last = mem_iaddr;
            mem_cnt  = 0;
         end
         if (mem_cnt < wait_cfg) begin
            mem_iwait = 1'b1;
            mem_iload = $urandom;
            mem_cnt++;
         end else begin
            mem_iwait = 1'b0;
            mem_iload = mem_fn(mem_iaddr);
            accepted.push_back(mem_iaddr);
            mem_have  = 0;
         end
      end
   end

   task automatic apply_reset;
      @(negedge CLK);
      RST         = 1'b1;
      icache_REN  = 1'b0;
      icache_halt = 1'b0;
      icache_addr = '0;
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      for (int i = 0; i < 8; i++) begin
         m_valid[i] = 0;
         m_tag[i]   = '0;
      end
      accepted.delete();
   endtask

   // One fetch: hit expected in cycle 0, or a full block fill with 3+2*wait cycles latency.
   task automatic access(input logic [31:0] a, input string nm);
      int          idx;
      logic [25:0] tg;
      bit          exp_hit;
      int          cycles;
      int          exp_cycles;
      logic [31:0] base;
      idx        = int'(a[5:3]);
      tg         = a[31:6];
      exp_hit    = m_valid[idx] && (m_tag[idx] == tg);
      exp_cycles = exp_hit ? 0 : 3 + 2 * wait_cfg;
      base       = {a[31:3], 3'b000};
      cycles     = 0;
      accepted.delete();
      @(negedge CLK);
      icache_REN  = 1'b1;
      icache_addr = a;
      #2;
      while (!icache_hit && cycles < 40) begin
         @(negedge CLK);
         #2;
         cycles++;
      end
      compared++;
      if (cycles !== exp_cycles) begin
         mismatched++;
         $display("FAIL %s latency addr=%h: got %0d cycles required %0d", nm, a, cycles, exp_cycles);
      end
      compared++;
      if (icache_load !== mem_fn(a)) begin
         mismatched++;
         $display("FAIL %s load addr=%h: got %h required %h", nm, a, icache_load, mem_fn(a));
      end
      compared++;
      if (exp_hit ? (accepted.size() != 0)
                  : (accepted.size() != 2 || accepted[0] !== base || accepted[1] !== base + 32'd4)) begin
         mismatched++;
         $display("FAIL %s mem_reqs addr=%h: got %0d words required %0d", nm, a, accepted.size(),
                  exp_hit ? 0 : 2);
      end
      m_valid[idx] = 1;
      m_tag[idx]   = tg;
   endtask

   task automatic test_reset;
      apply_reset();
      icache_addr = 32'h44;
      #2;
      compared++;
      if (icache_hit !== 1'b0 || mem_iREN !== 1'b0 || mem_iaddr !== 32'h0) begin
         mismatched++;
         $display("FAIL reset_outputs: got hit=%b iREN=%b iaddr=%h required 0/0/0", icache_hit, mem_iREN, mem_iaddr);
      end
      compared++;
      if (icache_load !== 32'h0 || hit_count !== 32'h0 || miss_count !== 32'h0) begin
         mismatched++;
         $display("FAIL reset_data: got load=%h hits=%0d misses=%0d required 0", icache_load, hit_count, miss_count);
      end
   endtask

   task automatic test_cold_miss;
      wait_cfg = 0;
      access(32'h40, "cold_miss");
      access(32'h44, "same_block");
   endtask

   task automatic test_conflict;
      wait_cfg = 0;
      access(32'h240, "conflict_fill");
      access(32'h40, "conflict_refill");
   endtask

   task automatic test_wait_states;
      wait_cfg = 3;
      access(32'h1008, "wait_fill");
      access(32'h100C, "wait_reuse");
      wait_cfg = 0;
   endtask

   task automatic test_addr_change;
      int cycles;
      wait_cfg = 0;
      access(32'h440, "evict_pre");
      accepted.delete();
      @(negedge CLK);
      icache_REN  = 1'b1;
      icache_addr = 32'h40;
      #2;
      compared++;
      if (icache_hit !== 1'b0) begin
         mismatched++;
         $display("FAIL addr_change_miss: got hit=%b required 0", icache_hit);
      end
      @(negedge CLK);
      icache_addr = 32'h80;
      #2;
      cycles = 1;
      while (!icache_hit && cycles < 40) begin
         @(negedge CLK);
         #2;
         cycles++;
      end
      compared++;
      if (cycles !== 6 || icache_load !== mem_fn(32'h80)) begin
         mismatched++;
         $display("FAIL addr_change_hit: got %0d cycles load=%h required 6 cycles load=%h", cycles, icache_load, mem_fn(32'h80));
      end
      compared++;
      if (accepted.size() != 4 || accepted[0] !== 32'h40 || accepted[1] !== 32'h44 ||
          accepted[2] !== 32'h80 || accepted[3] !== 32'h84) begin
         mismatched++;
         $display("FAIL addr_change_reqs: got %0d words required 40,44,80,84", accepted.size());
      end
      m_valid[0] = 1;
      m_tag[0]   = 26'd2;
   endtask

   task automatic test_random;
      logic [31:0] a;
      for (int n = 0; n < 60; n++) begin
         wait_cfg = $urandom_range(0, 2);
         a = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 7)) << 3) |
             (32'($urandom_range(0, 1)) << 2) | 32'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) begin
            @(negedge CLK);
            icache_REN = 1'b0;
         end
         access(a, "random");
      end
      wait_cfg = 0;
   endtask

   task automatic test_perf;
      logic [31:0] exp_h;
      logic [31:0] exp_m;
`ifdef ICACHE_PERF_COUNTERS_EN
      exp_h = 32'd3;
      exp_m = 32'd1;
`else
      exp_h = 32'd0;
      exp_m = 32'd0;
`endif
      apply_reset();
      #2;
      compared++;
      if (hit_count !== 32'h0 || miss_count !== 32'h0) begin
         mismatched++;
         $display("FAIL perf_reset: got hits=%0d misses=%0d required 0/0", hit_count, miss_count);
      end
      wait_cfg = 0;
      access(32'h40, "perf_miss");
      access(32'h44, "perf_hit");
      access(32'h40, "perf_hit");
      @(negedge CLK);
      icache_REN = 1'b0;
      #2;
      compared++;
      if (hit_count !== exp_h || miss_count !== exp_m) begin
         mismatched++;
         $display("FAIL perf_counts: got hits=%0d misses=%0d required %0d/%0d", hit_count, miss_count, exp_h, exp_m);
      end
   endtask

   task automatic test_halt;
      int cycles;
      apply_reset();
      wait_cfg = 2;
      accepted.delete();
      @(negedge CLK);
      icache_REN  = 1'b1;
      icache_addr = 32'h40;
      #2;
      cycles = 0;
      while (accepted.size() == 0 && cycles < 20) begin
         @(negedge CLK);
         #2;
         cycles++;
      end
      @(negedge CLK);
      #2;
      compared++;
      if (mem_iREN !== 1'b1 || mem_iaddr !== 32'h44) begin
         mismatched++;
         $display("FAIL halt_in_fill1: got iREN=%b iaddr=%h required 1/00000044", mem_iREN, mem_iaddr);
      end
      icache_halt = 1'b1;
      #1;
      compared++;
      if (icache_hit !== 1'b0) begin
         mismatched++;
         $display("FAIL halt_hit_now: got %b required 0", icache_hit);
      end
      @(negedge CLK);
      icache_halt = 1'b0;
      for (int n = 0; n < 8; n++) begin
         icache_addr = (n % 2 == 0) ? 32'h40 : 32'h44;
         #2;
         compared++;
         if (mem_iREN !== 1'b0 || icache_hit !== 1'b0 || mem_iaddr !== 32'h0) begin
            mismatched++;
            $display("FAIL halted_idle: got iREN=%b hit=%b iaddr=%h required 0/0/0", mem_iREN, icache_hit, mem_iaddr);
         end
         @(negedge CLK);
      end
      apply_reset();
      wait_cfg = 0;
      access(32'h40, "post_halt_miss");
      @(negedge CLK);
      icache_halt = 1'b1;
      #2;
      compared++;
      if (icache_hit !== 1'b0) begin
         mismatched++;
         $display("FAIL halt_idle_gate: got hit=%b required 0", icache_hit);
      end
      apply_reset();
   endtask

   initial begin
      test_reset();
      test_cold_miss();
      test_conflict();
      test_wait_states();
      test_addr_change();
      test_random();
      test_perf();
      test_halt();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
